conf_seq_ctrl: RTL and testbench

CONF_SEQ_CTRL -- requirements
Module: conf_seq_ctrl

---
 rtl/conf_seq_ctrl.sv | 97 +++++++++
 tb/tb_conf_seq_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conf_seq_ctrl.sv
// conf_seq_ctrl: shift-enable sequencer with masked, stretched load strobes,
// a load counter and a timestamp-aligned gray-counter reset.
module conf_seq_ctrl #(
    parameter int NLOAD     = 2,
    parameter int DLY_WIDTH = 4,
    parameter int LDW_WIDTH = 3,
    parameter int TS_WIDTH  = 9
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 SEN,
    input  logic                 SLD,
    input  logic                 SREN_CONF,
    input  logic [NLOAD-1:0]     LD_MASK,
    input  logic [DLY_WIDTH-1:0] HOLD_DLY,
    input  logic [LDW_WIDTH-1:0] LD_WIDTH,
    input  logic                 RST_GRAY_CONF,
    input  logic                 ALIGN_EN,
    input  logic [TS_WIDTH-1:0]  TS,
    input  logic [TS_WIDTH-1:0]  ALIGN_VAL,
    output logic                 SR_EN,
    output logic [NLOAD-1:0]     LD,
    output logic                 RST_GRAY,
    output logic                 GRAY_PEND,
    output logic                 BUSY,
    output logic [15:0]          LD_CNT
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t               state;
    logic [DLY_WIDTH-1:0] cnt;
    logic [NLOAD-1:0]     mask;
    logic [LDW_WIDTH-1:0] st;
    logic                 sld_q;
    logic                 ld_edge;
    logic [NLOAD-1:0]     ld_mask;

    assign ld_edge   = SLD && !sld_q;
    assign ld_mask   = BUSY ? mask : LD_MASK;
    assign BUSY      = state != IDLE;
    // Gated by reset so the flag is quiet while the block is held in reset.
    assign GRAY_PEND = ALIGN_EN && !BUS_RST && (RST_GRAY != RST_GRAY_CONF);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state    <= IDLE;
            cnt      <= '0;
            mask     <= '0;
            SR_EN    <= 1'b0;
            sld_q    <= 1'b0;
            st       <= '0;
            LD       <= '0;
            LD_CNT   <= '0;
            RST_GRAY <= 1'b0;
        end else begin
            sld_q <= SLD;
            case (state)
                IDLE: begin
                    SR_EN <= SREN_CONF && !SEN;
                    if (SEN) begin
                        state <= SHIFT;
                        mask  <= LD_MASK;
                    end
                end
                SHIFT: begin
                    SR_EN <= 1'b0;
                    if (!SEN) begin
                        state <= (HOLD_DLY == '0) ? IDLE : HOLD;
                        cnt   <= HOLD_DLY;
                    end
                end
                HOLD: begin
                    SR_EN <= 1'b0;
                    cnt   <= cnt - DLY_WIDTH'(1);
                    state <= SEN ? SHIFT : (cnt == DLY_WIDTH'(1)) ? IDLE : HOLD;
                end
                default: begin
                    SR_EN <= 1'b0;
                    state <= IDLE;
                end
            endcase
            // st counts the remaining cycles of the stretch after the current one.
            if (ld_edge) begin
                st     <= LD_WIDTH;
                LD     <= ld_mask;
                LD_CNT <= LD_CNT + 16'd1;
            end else if (st != '0) begin
                st <= st - LDW_WIDTH'(1);
                LD <= ld_mask;
            end else begin
                LD <= '0;
            end
            if (!ALIGN_EN || TS == ALIGN_VAL)
                RST_GRAY <= RST_GRAY_CONF;
        end
    end
endmodule

// File: tb/tb_conf_seq_ctrl.sv
// tb_conf_seq_ctrl: directed scenario tests for conf_seq_ctrl.
module tb_conf_seq_ctrl;
    logic       BUS_CLK = 1'b0;
    logic       BUS_RST, SEN, SLD, SREN_CONF, RST_GRAY_CONF, ALIGN_EN;
    logic [1:0] LD_MASK;
    logic [3:0] HOLD_DLY;
    logic [2:0] LD_WIDTH;
    logic [8:0] TS, ALIGN_VAL;
    logic       SR_EN, RST_GRAY, GRAY_PEND, BUSY;
    logic [1:0] LD;
    logic [15:0] LD_CNT;
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    conf_seq_ctrl dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .SEN(SEN), .SLD(SLD),
        .SREN_CONF(SREN_CONF), .LD_MASK(LD_MASK), .HOLD_DLY(HOLD_DLY),
        .LD_WIDTH(LD_WIDTH), .RST_GRAY_CONF(RST_GRAY_CONF), .ALIGN_EN(ALIGN_EN),
        .TS(TS), .ALIGN_VAL(ALIGN_VAL), .SR_EN(SR_EN), .LD(LD),
        .RST_GRAY(RST_GRAY), .GRAY_PEND(GRAY_PEND), .BUSY(BUSY), .LD_CNT(LD_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic test_reset();
        BUS_RST = 1; SEN = 0; SLD = 0; SREN_CONF = 1; LD_MASK = 2'b11;
        HOLD_DLY = 0; LD_WIDTH = 0; RST_GRAY_CONF = 1; ALIGN_EN = 1;
        TS = 0; ALIGN_VAL = 0;
        tick(); tick();
        n_cmp++; if ({SR_EN, LD, RST_GRAY, GRAY_PEND, BUSY} !== 6'b0) begin
            n_bad++; $display("FAIL reset_outs: {SR_EN,LD,RST_GRAY,GRAY_PEND,BUSY}=%b want 000000",
                              {SR_EN, LD, RST_GRAY, GRAY_PEND, BUSY}); end
        n_cmp++; if (LD_CNT !== 16'd0) begin
            n_bad++; $display("FAIL reset_cnt: LD_CNT=%h want 0000", LD_CNT); end
        BUS_RST = 0; RST_GRAY_CONF = 0; ALIGN_EN = 0;
        tick();
        n_cmp++; if (SR_EN !== 1'b1) begin
            n_bad++; $display("FAIL reset_idle_sren: SR_EN=%b want 1", SR_EN); end
        SREN_CONF = 0;
        tick();
        n_cmp++; if (SR_EN !== 1'b0) begin
            n_bad++; $display("FAIL sren_conf0: SR_EN=%b want 0", SR_EN); end
        SREN_CONF = 1;
        tick();
    endtask

    task automatic test_hold_dly5();
        HOLD_DLY = 5; SEN = 1;
        tick();
        n_cmp++; if (SR_EN !== 1'b0 || BUSY !== 1'b1) begin
            n_bad++; $display("FAIL hold5_start: SR_EN=%b BUSY=%b want 0 1", SR_EN, BUSY); end
        for (int i = 0; i < 9; i++) begin
            tick();
            n_cmp++; if (SR_EN !== 1'b0 || BUSY !== 1'b1) begin
                n_bad++; $display("FAIL hold5_shift[%0d]: SR_EN=%b BUSY=%b want 0 1", i, SR_EN, BUSY); end
        end
        SEN = 0;
        for (int j = 0; j <= 6; j++) begin
            tick();
            n_cmp++; if (SR_EN !== (j == 6) || BUSY !== (j < 5)) begin
                n_bad++; $display("FAIL hold5_tail[%0d]: SR_EN=%b BUSY=%b want %b %b",
                                  j, SR_EN, BUSY, j == 6, j < 5); end
        end
    endtask

    task automatic test_hold_dly0();
        HOLD_DLY = 0; SEN = 1;
        tick();
        SEN = 0;
        tick();
        n_cmp++; if (SR_EN !== 1'b0 || BUSY !== 1'b0) begin
            n_bad++; $display("FAIL hold0_edge: SR_EN=%b BUSY=%b want 0 0", SR_EN, BUSY); end
        tick();
        n_cmp++; if (SR_EN !== 1'b1) begin
            n_bad++; $display("FAIL hold0_restore: SR_EN=%b want 1", SR_EN); end
    endtask

    task automatic test_hold_abort();
        HOLD_DLY = 8; SEN = 1;
        tick();
        SEN = 0;
        tick(); tick(); tick(); tick();
        SEN = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            n_cmp++; if (SR_EN !== 1'b0 || BUSY !== 1'b1) begin
                n_bad++; $display("FAIL abort_hold[%0d]: SR_EN=%b BUSY=%b want 0 1", i, SR_EN, BUSY); end
        end
        SEN = 0; HOLD_DLY = 0;
        tick(); tick();
        n_cmp++; if (SR_EN !== 1'b1 || BUSY !== 1'b0) begin
            n_bad++; $display("FAIL abort_exit: SR_EN=%b BUSY=%b want 1 0", SR_EN, BUSY); end
    endtask

    task automatic test_ld_mask();
        LD_MASK = 2'b10; SEN = 1;
        tick();
        LD_MASK = 2'b01; LD_WIDTH = 3;
        tick();
        SLD = 1;
        for (int j = 0; j <= 4; j++) begin
            tick();
            SLD = 0;
            n_cmp++; if (LD !== ((j < 4) ? 2'b10 : 2'b00)) begin
                n_bad++; $display("FAIL ld_latched[%0d]: LD=%b want %b", j, LD, (j < 4) ? 2'b10 : 2'b00); end
        end
        exp_cnt = exp_cnt + 16'd1;
        n_cmp++; if (LD_CNT !== exp_cnt) begin
            n_bad++; $display("FAIL ld_cnt1: LD_CNT=%h want %h", LD_CNT, exp_cnt); end
        SEN = 0; HOLD_DLY = 0;
        tick(); tick();
        SLD = 1;
        tick();
        SLD = 0;
        n_cmp++; if (LD !== 2'b01) begin
            n_bad++; $display("FAIL ld_live: LD=%b want 01", LD); end
        exp_cnt = exp_cnt + 16'd1;
        repeat (4) tick();
        n_cmp++; if (LD !== 2'b00 || LD_CNT !== exp_cnt) begin
            n_bad++; $display("FAIL ld_live_end: LD=%b LD_CNT=%h want 00 %h", LD, LD_CNT, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        LD_MASK = 2'b11; LD_WIDTH = 7; SLD = 1;
        tick();
        SLD = 0;
        n_cmp++; if (LD !== 2'b11) begin
            n_bad++; $display("FAIL b2b_first: LD=%b want 11", LD); end
        tick();
        SLD = 1;
        tick();
        SLD = 0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_cmp++; if (LD !== ((j < 8) ? 2'b11 : 2'b00)) begin
                n_bad++; $display("FAIL b2b_tail[%0d]: LD=%b want %b", j, LD, (j < 8) ? 2'b11 : 2'b00); end
        end
        exp_cnt = exp_cnt + 16'd2;
        n_cmp++; if (LD_CNT !== exp_cnt) begin
            n_bad++; $display("FAIL b2b_cnt: LD_CNT=%h want %h", LD_CNT, exp_cnt); end
        force dut.LD_CNT = 16'hFFFF;
        #1;
        release dut.LD_CNT;
        SLD = 1;
        tick();
        SLD = 0;
        n_cmp++; if (LD_CNT !== 16'h0000) begin
            n_bad++; $display("FAIL cnt_wrap: LD_CNT=%h want 0000", LD_CNT); end
        repeat (9) tick();
    endtask

    task automatic test_gray();
        ALIGN_EN = 1; ALIGN_VAL = 9'h1F0; RST_GRAY_CONF = 1;
        for (int n = 9'h100; n <= 9'h1F0; n++) begin
            TS = 9'(n);
            #1;
            n_cmp++; if (GRAY_PEND !== 1'b1) begin
                n_bad++; $display("FAIL gray_pend[%h]: GRAY_PEND=%b want 1", n, GRAY_PEND); end
            tick();
            n_cmp++; if (RST_GRAY !== (n == 9'h1F0)) begin
                n_bad++; $display("FAIL gray_align[%h]: RST_GRAY=%b want %b", n, RST_GRAY, n == 9'h1F0); end
        end
        n_cmp++; if (GRAY_PEND !== 1'b0) begin
            n_bad++; $display("FAIL gray_pend_clear: GRAY_PEND=%b want 0", GRAY_PEND); end
        TS = 9'h1EF; RST_GRAY_CONF = 0;
        tick();
        n_cmp++; if (RST_GRAY !== 1'b1 || GRAY_PEND !== 1'b1) begin
            n_bad++; $display("FAIL gray_nomatch: RST_GRAY=%b GRAY_PEND=%b want 1 1", RST_GRAY, GRAY_PEND); end
        TS = 9'h1F0;
        tick();
        n_cmp++; if (RST_GRAY !== 1'b0 || GRAY_PEND !== 1'b0) begin
            n_bad++; $display("FAIL gray_coincide: RST_GRAY=%b GRAY_PEND=%b want 0 0", RST_GRAY, GRAY_PEND); end
        ALIGN_EN = 0; TS = 9'h005; RST_GRAY_CONF = 1;
        #1;
        n_cmp++; if (RST_GRAY !== 1'b0 || GRAY_PEND !== 1'b0) begin
            n_bad++; $display("FAIL gray_follow_pre: RST_GRAY=%b GRAY_PEND=%b want 0 0", RST_GRAY, GRAY_PEND); end
        tick();
        n_cmp++; if (RST_GRAY !== 1'b1 || GRAY_PEND !== 1'b0) begin
            n_bad++; $display("FAIL gray_follow: RST_GRAY=%b GRAY_PEND=%b want 1 0", RST_GRAY, GRAY_PEND); end
        RST_GRAY_CONF = 0;
        tick();
        n_cmp++; if (RST_GRAY !== 1'b0) begin
            n_bad++; $display("FAIL gray_follow_fall: RST_GRAY=%b want 0", RST_GRAY); end
    endtask

    task automatic test_reset_mid();
        HOLD_DLY = 8; LD_WIDTH = 7; LD_MASK = 2'b11; SEN = 1;
        tick();
        SEN = 0;
        tick();
        SLD = 1;
        tick();
        SLD = 0;
        n_cmp++; if (BUSY !== 1'b1 || LD !== 2'b11) begin
            n_bad++; $display("FAIL mid_pre: BUSY=%b LD=%b want 1 11", BUSY, LD); end
        exp_cnt = 16'd1;
        n_cmp++; if (LD_CNT !== exp_cnt) begin
            n_bad++; $display("FAIL mid_pre_cnt: LD_CNT=%h want %h", LD_CNT, exp_cnt); end
        BUS_RST = 1; RST_GRAY_CONF = 1;
        tick();
        n_cmp++; if ({SR_EN, LD, RST_GRAY, GRAY_PEND, BUSY} !== 6'b0 || LD_CNT !== 16'd0) begin
            n_bad++; $display("FAIL mid_reset: outs=%b LD_CNT=%h want 000000 0000",
                              {SR_EN, LD, RST_GRAY, GRAY_PEND, BUSY}, LD_CNT); end
        BUS_RST = 0; RST_GRAY_CONF = 0;
        tick();
        n_cmp++; if (LD !== 2'b00 || BUSY !== 1'b0 || SR_EN !== 1'b1) begin
            n_bad++; $display("FAIL mid_post: LD=%b BUSY=%b SR_EN=%b want 00 0 1", LD, BUSY, SR_EN); end
        tick();
        n_cmp++; if (LD !== 2'b00 || LD_CNT !== 16'd0) begin
            n_bad++; $display("FAIL mid_post2: LD=%b LD_CNT=%h want 00 0000", LD, LD_CNT); end
    endtask

    initial begin
        test_reset();
        test_hold_dly5();
        test_hold_dly0();
        test_hold_abort();
        test_ld_mask();
        test_back_to_back();
        test_gray();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
